axi_wr_traffic_gen: RTL and testbench

Synthesizable AXI write-channel traffic master that replaces force-driven stimulus on the fake CPU's AW/W/B channels. On a start pulse it issues NUM_TXN single-beat writes with parametrised address/data sequences. AW and W run as independent handshakes, and up to MAX_OUTST writes may await B responses. It sits in front of the axi_sram_bridge slave port in top-level benches and bring-up builds.

---
 rtl/axi_wr_traffic_gen.sv | 162 ++++++++++++++++
 tb/tb_axi_wr_traffic_gen.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_traffic_gen.sv
// AXI write-channel traffic master: NUM_TXN single-beat writes per start pulse, AW/W decoupled, bounded outstanding B.
// Define AXI_WR_GEN_BCHECK_EN to flag non-OKAY or wrong-ID B responses on the sticky err output.
module axi_wr_traffic_gen #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 64,
  parameter int                ID_W        = 4,
  parameter int                NUM_TXN     = 3,
  parameter logic [ADDR_W-1:0] ADDR_BASE   = 32'h4,
  parameter logic [ADDR_W-1:0] ADDR_STRIDE = 32'h100,
  parameter logic [DATA_W-1:0] DATA_SEED   = 64'habcdaaaa12345678,
  parameter logic [DATA_W-1:0] DATA_INC    = 64'h1111111111111111,
  parameter logic [2:0]        AWSIZE      = 3'h2,
  parameter logic [ID_W-1:0]   TXN_ID      = '0,
  parameter int                MAX_OUTST   = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ID_W-1:0]     awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awsize,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_W-1:0]     bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [7:0]          resp_cnt
);

  // state | meaning
  // IDLE  | after reset, waiting for start
  // ISSUE | presenting AW/W for the run, accepting B
  // DRAIN | every AW and W accepted, waiting for remaining B
  // DONE  | run complete, waiting for next start
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [7:0] NUM_L  = 8'(NUM_TXN);
  localparam logic [3:0] OUTS_L = 4'(MAX_OUTST);

  state_t              state, state_n;
  logic [7:0]          aw_idx, aw_idx_n;
  logic [7:0]          w_idx, w_idx_n;
  logic [3:0]          outst, outst_n;
  logic [7:0]          resp_cnt_n;
  logic [ADDR_W-1:0]   addr_acc, addr_acc_n;
  logic [DATA_W-1:0]   data_acc, data_acc_n;
  logic                awvalid_n, wvalid_n;
  logic                aw_hs, w_hs, b_hs, b_dec, start_ok;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      aw_idx   <= 8'd0;
      w_idx    <= 8'd0;
      outst    <= 4'd0;
      resp_cnt <= 8'd0;
      addr_acc <= '0;
      data_acc <= '0;
      awvalid  <= 1'b0;
      wvalid   <= 1'b0;
    end else begin
      state    <= state_n;
      aw_idx   <= aw_idx_n;
      w_idx    <= w_idx_n;
      outst    <= outst_n;
      resp_cnt <= resp_cnt_n;
      addr_acc <= addr_acc_n;
      data_acc <= data_acc_n;
      awvalid  <= awvalid_n;
      wvalid   <= wvalid_n;
    end
  end

  always_comb begin
    aw_hs    = awvalid & awready;
    w_hs     = wvalid & wready;
    b_hs     = bvalid & bready;
    b_dec    = b_hs && (outst != 4'd0);
    start_ok = start && (state == IDLE || state == DONE);

    state_n    = state;
    aw_idx_n   = aw_idx + {7'd0, aw_hs};
    w_idx_n    = w_idx + {7'd0, w_hs};
    resp_cnt_n = resp_cnt + {7'd0, (b_hs && resp_cnt < NUM_L)};
    addr_acc_n = aw_hs ? addr_acc + ADDR_STRIDE : addr_acc;
    data_acc_n = w_hs ? data_acc + DATA_INC : data_acc;
    outst_n    = outst;
    if (aw_hs && !b_dec)
      outst_n = outst + 4'd1;
    else if (!aw_hs && b_dec)
      outst_n = outst - 4'd1;

    case (state)
      IDLE:  if (start_ok) state_n = ISSUE;
      ISSUE: if (aw_idx_n == NUM_L && w_idx_n == NUM_L) state_n = DRAIN;
      DRAIN: if (resp_cnt_n == NUM_L) state_n = DONE;
      DONE:  if (start_ok) state_n = ISSUE;
      default: state_n = IDLE;
    endcase

    if (start_ok) begin
      aw_idx_n   = 8'd0;
      w_idx_n    = 8'd0;
      outst_n    = 4'd0;
      resp_cnt_n = 8'd0;
      addr_acc_n = ADDR_BASE;
      data_acc_n = DATA_SEED;
    end

    // A stalled beat holds; otherwise the next write is presented back-to-back if eligible.
    if (awvalid && !awready)
      awvalid_n = 1'b1;
    else
      awvalid_n = (state_n == ISSUE) && (aw_idx_n < NUM_L) && (outst_n < OUTS_L);

    if (wvalid && !wready)
      wvalid_n = 1'b1;
    else
      wvalid_n = (state_n == ISSUE) && (w_idx_n < aw_idx_n);
  end

  assign busy   = (state == ISSUE) || (state == DRAIN);
  assign bready = busy;
  assign done   = (state == DONE);

  // Payload is masked by valid so idle cycles show zeros.
  assign awaddr = awvalid ? addr_acc : '0;
  assign awsize = awvalid ? AWSIZE : 3'd0;
  assign awid   = awvalid ? TXN_ID : '0;
  assign wdata  = wvalid ? data_acc : '0;
  assign wstrb  = {(DATA_W/8){wvalid}};
  assign wlast  = wvalid;

`ifdef AXI_WR_GEN_BCHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!resetn)
      err_q <= 1'b0;
    else if (start_ok)
      err_q <= 1'b0;
    else if (b_hs && (bresp != 2'b00 || bid != TXN_ID))
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  logic unused_bchk;
  assign unused_bchk = ^{bid, bresp};
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_wr_traffic_gen.sv
// Self-checking bench for axi_wr_traffic_gen: table of randomized slave profiles plus directed corner sequences.
module tb_axi_wr_traffic_gen;

  localparam int          NUM_TXN     = 3;
  localparam int          MAX_OUTST   = 2;
  localparam logic [31:0] ADDR_BASE   = 32'h4;
  localparam logic [31:0] ADDR_STRIDE = 32'h100;
  localparam logic [63:0] DATA_SEED   = 64'habcdaaaa12345678;
  localparam logic [63:0] DATA_INC    = 64'h1111111111111111;

  logic        clk = 1'b0;
  logic        resetn, start, busy, done, err;
  logic [3:0]  awid, bid;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [63:0] wdata;
  logic [7:0]  wstrb, resp_cnt;
  logic [1:0]  bresp;

  always #5 clk = ~clk;

  axi_wr_traffic_gen dut (
    .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done), .err(err),
    .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready), .resp_cnt(resp_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: counts of accepted beats and the run status they imply.
  int          n_aw, n_w, n_b;
  bit          m_busy, m_done, m_err;
  bit          prev_aw_stall, prev_w_stall, b_hold;
  logic [31:0] prev_awaddr, last_awaddr;
  logic [63:0] prev_wdata, last_wdata;
  int          err_on_b = -1;

  typedef struct {
    int          aw_pct;
    int          w_pct;
    int          b_pct;
    int          exp_resp;
    logic [31:0] exp_last_addr;
    logic [63:0] exp_last_data;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int i);
    return ADDR_BASE + 32'(i) * ADDR_STRIDE;
  endfunction

  function automatic logic [63:0] exp_data(input int i);
    return DATA_SEED + 64'(i) * DATA_INC;
  endfunction

  function automatic bit bad_b(input logic [1:0] r, input logic [3:0] id);
    return (r != 2'b00) || (id != 4'd0);
  endfunction

  // Called just after a negedge with inputs applied; checks, records handshakes, advances one cycle.
  task automatic step();
    bit aw_hs, w_hs, b_hs;
    #1;
    if (resetn) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("bready", bready, m_busy);
      chk("resp_cnt", resp_cnt, (n_b > NUM_TXN) ? NUM_TXN : n_b);
      if (prev_aw_stall) begin
        chk("aw_hold_valid", awvalid, 1);
        chk("aw_hold_addr", awaddr, prev_awaddr);
      end
      if (prev_w_stall) begin
        chk("w_hold_valid", wvalid, 1);
        chk("w_hold_data", wdata, prev_wdata);
      end
      if (wvalid) chk("w_after_aw", n_w < n_aw, 1);
      if (awvalid) chk("aw_outst_limit", (n_aw - n_b) < MAX_OUTST, 1);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      if (aw_hs) begin
        chk("awaddr", awaddr, exp_addr(n_aw));
        chk("awsize", awsize, 3'h2);
        chk("awid", awid, 4'h0);
        last_awaddr = awaddr;
        n_aw++;
      end
      if (w_hs) begin
        chk("wdata", wdata, exp_data(n_w));
        chk("wstrb", wstrb, 8'hff);
        chk("wlast", wlast, 1);
        last_wdata = wdata;
        n_w++;
      end
      if (b_hs) begin
        n_b++;
`ifdef AXI_WR_GEN_BCHECK_EN
        if (bad_b(bresp, bid)) m_err = 1'b1;
`endif
      end
      if (start && !m_busy) begin
        m_busy = 1'b1; m_done = 1'b0; m_err = 1'b0;
        n_aw = 0; n_w = 0; n_b = 0;
      end else if (b_hs && m_busy && n_b == NUM_TXN) begin
        m_busy = 1'b0; m_done = 1'b1;
      end
      prev_aw_stall = awvalid && !awready;
      prev_awaddr   = awaddr;
      prev_w_stall  = wvalid && !wready;
      prev_wdata    = wdata;
      b_hold        = bvalid && !bready;
    end else begin
      m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
      n_aw = 0; n_w = 0; n_b = 0;
      prev_aw_stall = 1'b0; prev_w_stall = 1'b0; b_hold = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic drive_rand(input int aw_pct, input int w_pct, input int b_pct);
    int pend;
    awready = int'($urandom_range(99)) < aw_pct;
    wready  = int'($urandom_range(99)) < w_pct;
    if (!b_hold) begin
      pend   = ((n_aw < n_w) ? n_aw : n_w) - n_b;
      bvalid = (pend > 0) && (int'($urandom_range(99)) < b_pct);
      bid    = 4'd0;
      bresp  = (n_b == err_on_b) ? 2'b10 : 2'b00;
    end
  endtask

  task automatic do_start();
    start = 1'b1; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    step();
    start = 1'b0;
    chk("first_awvalid", awvalid, 1);
    chk("first_awaddr", awaddr, ADDR_BASE);
    chk("first_wvalid", wvalid, 0);
  endtask

  task automatic run_to_done(input int aw_pct, input int w_pct, input int b_pct);
    int cyc = 0;
    while (!m_done && cyc < 1000) begin
      drive_rand(aw_pct, w_pct, b_pct);
      step();
      cyc++;
    end
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    chk("run_done", done, 1);
    chk("run_busy", busy, 0);
    chk("run_resp_cnt", resp_cnt, NUM_TXN);
    chk("run_awvalid", awvalid, 0);
    chk("run_wvalid", wvalid, 0);
    chk("run_bready", bready, 0);
  endtask

  initial begin
    vecs[0] = '{100, 100, 100, 3, 32'h204, 64'hcdefcccc3456789a};
    vecs[1] = '{ 50, 100, 100, 3, 32'h204, 64'hcdefcccc3456789a};
    vecs[2] = '{100,  30, 100, 3, 32'h204, 64'hcdefcccc3456789a};
    vecs[3] = '{ 70,  70,  20, 3, 32'h204, 64'hcdefcccc3456789a};
    vecs[4] = '{ 20,  25,  50, 3, 32'h204, 64'hcdefcccc3456789a};

    resetn = 1'b0; start = 1'b0; awready = 1'b0; wready = 1'b0;
    bvalid = 1'b0; bid = 4'd0; bresp = 2'b00;
    @(negedge clk);
    step();
    step();
    resetn = 1'b1;
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_resp_cnt", resp_cnt, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    step();

    for (int v = 0; v < 5; v++) begin
      do_start();
      run_to_done(vecs[v].aw_pct, vecs[v].w_pct, vecs[v].b_pct);
      chk("vec_resp", resp_cnt, vecs[v].exp_resp);
      chk("vec_n_aw", n_aw, NUM_TXN);
      chk("vec_n_w", n_w, NUM_TXN);
      chk("vec_last_addr", last_awaddr, vecs[v].exp_last_addr);
      chk("vec_last_data", last_wdata, vecs[v].exp_last_data);
      step();
    end

    // AW stall: address held, W waits, start during the run is ignored.
    do_start();
    for (int k = 0; k < 4; k++) begin
      awready = 1'b0; wready = 1'b1; bvalid = 1'b0; start = (k == 2);
      step();
      start = 1'b0;
      chk("stall_awvalid", awvalid, 1);
      chk("stall_awaddr", awaddr, 32'h4);
      chk("stall_wvalid", wvalid, 0);
    end
    run_to_done(100, 100, 100);

    // Withheld B: only MAX_OUTST AWs go out until a response returns.
    do_start();
    for (int k = 0; k < 6; k++) begin
      awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
      step();
    end
    chk("wb_n_aw", n_aw, 2);
    chk("wb_n_w", n_w, 2);
    chk("wb_awvalid", awvalid, 0);
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bid = 4'd0; bresp = 2'b00;
    step();
    bvalid = 1'b0;
    chk("wb_awvalid_after_b", awvalid, 1);
    chk("wb_awaddr_after_b", awaddr, 32'h204);
    run_to_done(100, 100, 100);

    // AW and B handshakes on the same edge leave the outstanding count at 1.
    do_start();
    awready = 1'b1; wready = 1'b0; bvalid = 1'b0;
    step();
    awready = 1'b0; wready = 1'b1;
    step();
    awready = 1'b1; wready = 1'b0; bvalid = 1'b1; bid = 4'd0; bresp = 2'b00;
    step();
    bvalid = 1'b0;
    chk("sim_awvalid", awvalid, 1);
    chk("sim_awaddr", awaddr, 32'h204);
    run_to_done(100, 100, 100);
    chk("sim_resp_cnt", resp_cnt, 3);

    // Reset during DRAIN abandons the run; a fresh run starts from write 0.
    do_start();
    for (int g = 0; g < 100 && n_w < NUM_TXN; g++) begin
      drive_rand(100, 100, 100);
      step();
    end
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    step();
    chk("drain_busy", busy, 1);
    chk("drain_awvalid", awvalid, 0);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("mid_rst_awvalid", awvalid, 0);
    chk("mid_rst_wvalid", wvalid, 0);
    chk("mid_rst_bready", bready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_resp_cnt", resp_cnt, 0);
    chk("mid_rst_awaddr", awaddr, 0);
    chk("mid_rst_wdata", wdata, 0);
    chk("mid_rst_wstrb", wstrb, 0);
    chk("mid_rst_wlast", wlast, 0);
    chk("mid_rst_awsize", awsize, 0);
    step();
    do_start();
    run_to_done(60, 60, 60);

    // Error response on write 1: err is sticky only when checking is built in; start clears it.
    err_on_b = 1;
    do_start();
    run_to_done(100, 100, 100);
    chk("bchk_done", done, 1);
`ifdef AXI_WR_GEN_BCHECK_EN
    chk("bchk_err", err, 1);
`else
    chk("bchk_err", err, 0);
`endif
    err_on_b = -1;
    do_start();
    chk("bchk_err_cleared", err, 0);
    run_to_done(100, 100, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
